fir_wyn_stream: RTL and testbench
=================================

Name: fir_wyn_stream

Overview:
- Downstream stage of the FIR core.
- Captures each result the FIR writes out (write strobe, result address, 16-bit sample) into a small FIFO.
- Presents the results to the host side as a valid/ready stream, with a last-sample marker, sequence checking and a completion pulse.
- Decouples the FIR output timing from host back-pressure.

Parameters:
- DATA_W, 16, result sample width
- ADDR_W, 13, FIR result address width
- CNT_W, 14, sample-count width (holds up to 2^ADDR_W)
- DEPTH, 16, FIFO entries; power of two, >= 2

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run start pulse (same pulse as the FIR start); clears the block and arms it
- ile_probek  in  CNT_W  expected number of result samples N, sampled on start
- wr  in  1  FIR result write strobe
- wr_addr  in  ADDR_W  FIR result address
- wr_data  in  DATA_W  FIR result sample
- fir_done  in  1  FIR run-complete pulse
- m_data  out  DATA_W  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready from consumer
- m_last  out  1  marks sample number N (index N-1)
- busy  out  1  high in ACTIVE and DRAIN
- overflow  out  1  sticky: a result was dropped because the FIFO was full
- seq_err  out  1  sticky: address gap, or more than N writes
- sent_cnt  out  CNT_W  samples transferred on the stream this run
- stream_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). All outputs are 0, the FIFO is empty, the state is IDLE, and N and all counters are 0.
- State IDLE: writes are ignored and m_valid=0. start -> ACTIVE; N<=ile_probek, pointers, exp_addr, sent_cnt, overflow and seq_err are cleared.
- State ACTIVE:
  - A write is accepted when wr=1, the FIFO is not full, and accepted-write count < N.
  - Exception for the full case: a write is still accepted when the FIFO is full if a pop happens in the same cycle (m_valid&m_ready).
  - wr=1 with the FIFO full and no pop: the sample is dropped and overflow<=1.
  - wr=1 after N writes have been accepted: the sample is dropped and seq_err<=1.
  - Address check: on each wr, if wr_addr != exp_addr then seq_err<=1. The sample is still stored, and exp_addr<=wr_addr+1 modulo 2^ADDR_W.
  - fir_done -> DRAIN. A wr in the same cycle as fir_done is still processed.
- State DRAIN: writes are ignored, with no flag set. When the FIFO is empty -> DONE.
- Early exit: in ACTIVE, when sent_cnt reaches N, go to DONE without waiting for fir_done.
- State DONE: stream_done=1 for exactly one cycle, then IDLE. The flags and sent_cnt hold their values until the next start.
- N=0: no samples are accepted (all writes set seq_err); the block goes to DONE once fir_done arrives and the FIFO is empty.
- start in any non-IDLE state: restart. The FIFO is flushed, flags are cleared, N is re-sampled, and the state is ACTIVE. start has priority over every other event.
- Stream: first-word-fall-through.
  - Latency: a write accepted at cycle t gives m_valid=1 at t+1 if the FIFO was empty.
  - m_valid = FIFO not empty.
  - Transfer on m_valid&m_ready; sent_cnt increments by 1 per transfer and saturates at N.
  - m_data and m_last are held stable while m_valid&!m_ready.
  - m_last=1 exactly when m_valid and sent_cnt==N-1.
- FIFO: read and write pointers are ADDR of DEPTH plus one wrap bit. The count is never greater than DEPTH.

Test Plan:
- Basic stream: start with N=4; writes at addr 0..3 with data 0x0001, 0x7FFF, 0x8000, 0xFFFF; m_ready=1 -> four beats with identical data, each one cycle after its write; m_last on 0xFFFF; sent_cnt=4; stream_done pulses once; busy drops; flags stay 0.
- Back-pressure and overflow: DEPTH=16, N=20, m_ready=0, 17 consecutive writes -> overflow=1 on the 17th; m_data holds the first sample; then m_ready=1 -> 16 beats in order, no m_last.
- Sequence error: N=3, writes at addr 0,2,3 -> seq_err=1 at the addr-2 write; all 3 samples are streamed; m_last is on the third.
- Full with simultaneous pop: fill 16 entries, then wr and m_ready in the same cycle -> the write is accepted, the count stays 16, overflow stays 0.
- Early fir_done / N=0: with N=0, start then fir_done -> stream_done 2 cycles after fir_done, m_valid never high. With N=5, 2 writes then fir_done -> DRAIN empties 2 beats, then stream_done with sent_cnt=2.
- Restart and reset mid-run: start issued in ACTIVE with 3 entries queued -> m_valid=0 the next cycle, flags cleared. rst_n low mid-stream -> all outputs are 0 immediately and asynchronously.

Source files
------------

// File: rtl/fir_wyn_stream.sv
// FIR result capture FIFO presented as a valid/ready stream.
// Adds a last-sample marker, address sequence checks and a completion pulse.
module fir_wyn_stream #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 13,
   parameter int CNT_W  = 14,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  ile_probek,
   input  logic              wr,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              fir_done,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              overflow,
   output logic              seq_err,
   output logic [CNT_W-1:0]  sent_cnt,
   output logic              stream_done
);

   localparam int PW = $clog2(DEPTH);
   localparam int AW = PW + 1;
   localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [CNT_W-1:0]    sent_q, sent_d;
   logic [CNT_W-1:0]    acc_q, acc_d;
   logic [ADDR_W-1:0]   exp_q, exp_d;
   logic [AW-1:0]       wp_q, wp_d;
   logic [AW-1:0]       rp_q, rp_d;
   logic                ovf_q, ovf_d;
   logic                seq_q, seq_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   mem_d [DEPTH];

   logic [AW-1:0]       count;
   logic                empty;
   logic                full;
   logic                pop;
   logic                in_act;
   logic                room;
   logic                below_n;
   logic                push;

   assign count   = wp_q - rp_q;
   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign pop     = !empty && m_ready;
   assign in_act  = (state_q == S_ACTIVE);
   // A full FIFO still has room when the head leaves this cycle.
   assign room    = !full || pop;
   assign below_n = (acc_q < n_q);
   assign push    = in_act && wr && below_n && room;

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      sent_d  = sent_q;
      acc_d   = acc_q;
      exp_d   = exp_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      ovf_d   = ovf_q;
      seq_d   = seq_q;
      mem_d   = mem_q;

      if (start) begin
         state_d = S_ACTIVE;
         n_d     = ile_probek;
         sent_d  = '0;
         acc_d   = '0;
         exp_d   = '0;
         wp_d    = '0;
         rp_d    = '0;
         ovf_d   = 1'b0;
         seq_d   = 1'b0;
      end else begin
         if (pop) begin
            rp_d = rp_q + AW'(1);
            if (sent_q != n_q) begin
               sent_d = sent_q + CNT_W'(1);
            end
         end

         if (push) begin
            mem_d[wp_q[PW-1:0]] = wr_data;
            wp_d  = wp_q + AW'(1);
            acc_d = acc_q + CNT_W'(1);
         end

         if (in_act && wr) begin
            if (wr_addr != exp_q) begin
               seq_d = 1'b1;
            end
            exp_d = wr_addr + ADDR_W'(1);
            if (!below_n) begin
               seq_d = 1'b1;
            end else if (!room) begin
               ovf_d = 1'b1;
            end
         end

         unique case (state_q)
            S_IDLE: begin
               state_d = S_IDLE;
            end
            S_ACTIVE: begin
               // All N samples delivered: no need to wait for fir_done.
               if (pop && (sent_q + CNT_W'(1) == n_q)) begin
                  state_d = S_DONE;
               end else if (fir_done) begin
                  state_d = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (empty) begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         sent_q  <= '0;
         acc_q   <= '0;
         exp_q   <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         ovf_q   <= 1'b0;
         seq_q   <= 1'b0;
         mem_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         sent_q  <= sent_d;
         acc_q   <= acc_d;
         exp_q   <= exp_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         ovf_q   <= ovf_d;
         seq_q   <= seq_d;
         mem_q   <= mem_d;
      end
   end

   assign m_valid     = !empty;
   assign m_data      = m_valid ? mem_q[rp_q[PW-1:0]] : '0;
   assign m_last      = m_valid && (n_q != '0) &&
                        (sent_q == n_q - CNT_W'(1));
   assign busy        = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
   assign overflow    = ovf_q;
   assign seq_err     = seq_q;
   assign sent_cnt    = sent_q;
   assign stream_done = (state_q == S_DONE);

endmodule

// File: tb/tb_fir_wyn_stream.sv
// Scoreboard bench for fir_wyn_stream: directed runs, monitor checks beats.
module tb_fir_wyn_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [13:0] ile_probek = '0;
   logic        wr = 1'b0;
   logic [12:0] wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        fir_done = 1'b0;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        m_last;
   logic        busy;
   logic        overflow;
   logic        seq_err;
   logic [13:0] sent_cnt;
   logic        stream_done;

   int total = 0;
   int bad = 0;
   logic [16:0] sb [$];

   fir_wyn_stream dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .ile_probek(ile_probek), .wr(wr), .wr_addr(wr_addr),
      .wr_data(wr_data), .fir_done(fir_done), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .busy(busy), .overflow(overflow), .seq_err(seq_err),
      .sent_cnt(sent_cnt), .stream_done(stream_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Beat transfers at the next posedge; sample it half a cycle early.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected: got %0h want none", m_data);
         end else begin
            logic [16:0] e;
            e = sb.pop_front();
            chk("beat_data", 32'(m_data), 32'(e[15:0]));
            chk("beat_last", 32'(m_last), 32'(e[16]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [13:0] n);
      start = 1'b1;
      ile_probek = n;
      tick();
      start = 1'b0;
   endtask

   task automatic wr_one(input logic [12:0] a, input logic [15:0] d);
      wr = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr = 1'b0;
   endtask

   task automatic pulse_done();
      fir_done = 1'b1;
      tick();
      fir_done = 1'b0;
   endtask

   task automatic window(input int k, output int p);
      p = 0;
      repeat (k) begin
         if (stream_done === 1'b1) p++;
         tick();
      end
   endtask

   initial begin
      int p;
      logic [15:0] t1 [4];
      t1 = '{16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(m_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_sent", 32'(sent_cnt), 0);
      chk("rst_flags", 32'({overflow, seq_err, stream_done, m_last}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // basic stream
      m_ready = 1'b1;
      do_start(14'd4);
      for (int i = 0; i < 4; i++) begin
         sb.push_back({(i == 3), t1[i]});
         wr_one(13'(i), t1[i]);
         if (i == 0) begin
            chk("t1_lat_valid", 32'(m_valid), 1);
            chk("t1_lat_data", 32'(m_data), 32'h0001);
         end
      end
      window(6, p);
      chk("t1_done_pulses", p, 1);
      chk("t1_sent", 32'(sent_cnt), 4);
      chk("t1_busy", 32'(busy), 0);
      chk("t1_flags", 32'({overflow, seq_err}), 0);

      // back-pressure and overflow
      m_ready = 1'b0;
      do_start(14'd20);
      for (int i = 0; i < 17; i++) begin
         if (i < 16) sb.push_back({1'b0, 16'(16'h1000 + i)});
         wr_one(13'(i), 16'(16'h1000 + i));
         if (i == 15) chk("t2_ovf_before", 32'(overflow), 0);
      end
      chk("t2_ovf_after", 32'(overflow), 1);
      chk("t2_hold_data", 32'(m_data), 32'h1000);
      m_ready = 1'b1;
      repeat (20) tick();
      chk("t2_sb_empty", sb.size(), 0);
      chk("t2_sent", 32'(sent_cnt), 16);
      pulse_done();
      window(5, p);
      chk("t2_done_pulses", p, 1);

      // sequence error
      do_start(14'd3);
      sb.push_back({1'b0, 16'hA000});
      sb.push_back({1'b0, 16'hA002});
      sb.push_back({1'b1, 16'hA003});
      wr_one(13'd0, 16'hA000);
      chk("t3_seq_ok", 32'(seq_err), 0);
      wr_one(13'd2, 16'hA002);
      chk("t3_seq_gap", 32'(seq_err), 1);
      wr_one(13'd3, 16'hA003);
      window(6, p);
      chk("t3_done_pulses", p, 1);
      chk("t3_sent", 32'(sent_cnt), 3);

      // full with simultaneous pop
      m_ready = 1'b0;
      do_start(14'd20);
      for (int i = 0; i < 16; i++) begin
         sb.push_back({1'b0, 16'(16'h2000 + i)});
         wr_one(13'(i), 16'(16'h2000 + i));
      end
      sb.push_back({1'b0, 16'h2010});
      m_ready = 1'b1;
      wr_one(13'd16, 16'h2010);
      m_ready = 1'b0;
      chk("t4_ovf_pop", 32'(overflow), 0);
      wr_one(13'd17, 16'h2011);
      chk("t4_still_full", 32'(overflow), 1);
      m_ready = 1'b1;
      repeat (20) tick();
      chk("t4_sb_empty", sb.size(), 0);
      chk("t4_sent", 32'(sent_cnt), 17);
      pulse_done();
      window(5, p);
      chk("t4_done_pulses", p, 1);

      // N=0
      do_start(14'd0);
      wr_one(13'd0, 16'h0055);
      chk("t5_n0_seq", 32'(seq_err), 1);
      pulse_done();
      chk("t5_n0_done_early", 32'(stream_done), 0);
      tick();
      chk("t5_n0_done", 32'(stream_done), 1);
      tick();
      chk("t5_n0_busy", 32'(busy), 0);
      chk("t5_n0_sent", 32'(sent_cnt), 0);

      // early fir_done with drain
      m_ready = 1'b0;
      do_start(14'd5);
      sb.push_back({1'b0, 16'h3000});
      sb.push_back({1'b0, 16'h3001});
      wr_one(13'd0, 16'h3000);
      wr_one(13'd1, 16'h3001);
      pulse_done();
      chk("t5_drain_busy", 32'(busy), 1);
      chk("t5_drain_valid", 32'(m_valid), 1);
      m_ready = 1'b1;
      window(6, p);
      chk("t5_done_pulses", p, 1);
      chk("t5_sent", 32'(sent_cnt), 2);
      chk("t5_flags", 32'({overflow, seq_err}), 0);

      // restart mid-run
      m_ready = 1'b0;
      do_start(14'd8);
      wr_one(13'd0, 16'h4000);
      wr_one(13'd1, 16'h4001);
      wr_one(13'd5, 16'h4005);
      chk("t6_seq_pre", 32'(seq_err), 1);
      do_start(14'd8);
      chk("t6_flush", 32'(m_valid), 0);
      chk("t6_seq_clr", 32'(seq_err), 0);
      chk("t6_busy", 32'(busy), 1);

      // asynchronous reset mid-stream
      wr_one(13'd0, 16'h5000);
      wr_one(13'd1, 16'h5001);
      chk("t6_pre_valid", 32'(m_valid), 1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_arst_valid", 32'(m_valid), 0);
      chk("t6_arst_data", 32'(m_data), 0);
      chk("t6_arst_busy", 32'(busy), 0);
      chk("t6_arst_misc",
          32'({overflow, seq_err, stream_done, m_last, sent_cnt}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      wr_one(13'd0, 16'h6000);
      chk("t6_idle_ignore", 32'(m_valid), 0);

      chk("final_sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
